// File: rtl/ps2_cmd_sequencer_pkg.sv
// ps2_cmd_sequencer_pkg: PS/2 command/response codes and sequencer state types.
package ps2_cmd_sequencer_pkg;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT_ACK, S_WAIT_BAT, S_ERROR} ps2_seq_state_t;
    typedef enum logic [1:0] {PH_RESET, PH_LED_CMD, PH_LED_ARG} ps2_seq_phase_t;
endpackage

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer: loadable down-counter; expire_o pulses once when a loaded count runs out.
module ps2_timeout_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clr_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q;
    logic         run_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            run_q <= 1'b1;
        end else if (clr_i || (run_q && cnt_q == '0)) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = run_q && cnt_q == '0;
endmodule

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: keyboard bring-up, ACK-checked LED updates with retries, and scancode forwarding.
module ps2_cmd_sequencer
    import ps2_cmd_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int BAT_TIMEOUT = 75_000_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kbd_reset_i,
    input  logic       led_req_i,
    input  logic [2:0] led_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] key_data_o,
    output logic       key_valid_o,
    output logic       busy_o,
    output logic       kbd_ready_o,
    output logic       error_o
);
    localparam int TMAX = ACK_TIMEOUT > BAT_TIMEOUT ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW = $clog2(TMAX);
    localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] ACK_LD = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LD = TW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    ps2_seq_state_t state_q, state_d;
    ps2_seq_phase_t phase_q, phase_d;
    logic [7:0]    tx_q, tx_d, key_q, key_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]    led_q, led_d;
    logic          pend_q, pend_d, rdy_q, rdy_d, keyv_q, keyv_d;
    logic          txv_q, busy_q, err_q;
    logic          tm_load, tm_exp;
    logic [TW-1:0] tm_val;
    logic          rx_ack, rx_resend;

    assign rx_ack    = rx_valid_i && rx_data_i == PS2_RSP_ACK;
    assign rx_resend = rx_valid_i && rx_data_i == PS2_RSP_RESEND;

    ps2_timeout_timer #(.W(TW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tm_load),
        .clr_i      (!(state_d inside {S_WAIT_ACK, S_WAIT_BAT})),
        .load_val_i (tm_val),
        .expire_o   (tm_exp)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tx_d    = tx_q;
        retry_d = retry_q;
        pend_d  = pend_q | led_req_i;
        led_d   = led_req_i ? led_i : led_q;
        rdy_d   = rdy_q;
        key_d   = key_q;
        keyv_d  = 1'b0;
        tm_load = 1'b0;
        tm_val  = ACK_LD;
        if (kbd_reset_i) begin
            state_d = S_TX;
            phase_d = PH_RESET;
            tx_d    = PS2_CMD_RESET;
            retry_d = '0;
            rdy_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    keyv_d = rx_valid_i;
                    key_d  = rx_valid_i ? rx_data_i : key_q;
                    if (state_q == S_IDLE && pend_q) begin
                        state_d = S_TX;
                        phase_d = PH_LED_CMD;
                        tx_d    = PS2_CMD_SET_LEDS;
                        retry_d = '0;
                        pend_d  = led_req_i;
                    end
                end
                S_TX: if (txv_q && tx_ready_i) begin
                    state_d = S_WAIT_ACK;
                    tm_load = 1'b1;
                end
                S_WAIT_ACK: begin
                    // A meaningful rx byte is handled ahead of a same-cycle timeout.
                    if (rx_ack) begin
                        case (phase_q)
                            PH_RESET: begin
                                state_d = S_WAIT_BAT;
                                tm_load = 1'b1;
                                tm_val  = BAT_LD;
                            end
                            PH_LED_CMD: begin
                                state_d = S_TX;
                                phase_d = PH_LED_ARG;
                                tx_d    = {5'b0, led_q};
                                retry_d = '0;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end else if (rx_resend || tm_exp) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_ERROR;
                            rdy_d   = 1'b0;
                        end else begin
                            state_d = S_TX;
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end
                S_WAIT_BAT: begin
                    if (rx_valid_i && rx_data_i == PS2_RSP_BAT_OK) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                    end else if ((rx_valid_i && rx_data_i == PS2_RSP_BAT_FAIL) || tm_exp) begin
                        state_d = S_ERROR;
                        rdy_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered so they read 0 throughout reset although the FSM resets into S_TX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_TX;
            phase_q <= PH_RESET;
            tx_q    <= PS2_CMD_RESET;
            retry_q <= '0;
            led_q   <= '0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
            key_q   <= '0;
            keyv_q  <= 1'b0;
            txv_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tx_q    <= tx_d;
            retry_q <= retry_d;
            led_q   <= led_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            key_q   <= key_d;
            keyv_q  <= keyv_d;
            txv_q   <= state_d == S_TX && !kbd_reset_i;
            busy_q  <= state_d inside {S_TX, S_WAIT_ACK, S_WAIT_BAT};
            err_q   <= state_d == S_ERROR;
        end
    end

    assign tx_valid_o  = txv_q;
    assign tx_data_o   = txv_q ? tx_q : '0;
    assign key_data_o  = key_q;
    assign key_valid_o = keyv_q;
    assign busy_o      = busy_q;
    assign kbd_ready_o = rdy_q;
    assign error_o     = err_q;
endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Command sequencer sitting between the PS/2 byte transceiver (ps2_controller) and the CPU-side keyboard peripheral.
- Runs keyboard bring-up: sends reset 0xFF, waits for ACK, then waits for the BAT result.
- Services LED-update requests: sends 0xED followed by the LED byte, each ACK-checked.
- Handles resend requests and timeouts with a bounded retry count.
- Forwards all unsolicited received bytes (scancodes) upstream.

Parameters:
ACK_TIMEOUT, 2_000_000, cycles (20 ms at 100 MHz) to wait for a response after each transmitted byte.
BAT_TIMEOUT, 75_000_000, cycles (750 ms) to wait for the BAT result after the reset ACK.
MAX_RETRIES, 3, resends allowed per byte before declaring an error.

Ports:
clk_i  in  1  system clock, 100 MHz.
rst_i  in  1  asynchronous, active-high reset.
kbd_reset_i  in  1  pulse: restart the keyboard bring-up sequence.
led_req_i  in  1  pulse: request an LED update.
led_i  in  3  {caps, num, scroll}; sampled on the led_req_i cycle.
tx_data_o  out  8  byte to transmit to the transceiver.
tx_valid_o  out  1  tx_data_o is valid.
tx_ready_i  in  1  transceiver accepts the byte this cycle.
rx_data_i  in  8  byte received from the keyboard.
rx_valid_i  in  1  one-cycle strobe for rx_data_i.
key_data_o  out  8  forwarded scancode.
key_valid_o  out  1  one-cycle strobe for key_data_o.
busy_o  out  1  a command sequence is in progress.
kbd_ready_o  out  1  BAT passed and no error since.
error_o  out  1  sticky failure flag.

Behaviour:
- Reset values: every output is 0, all counters are 0, LED pending flag is 0.
- State after reset deassertion is S_TX with byte 0xFF, the auto bring-up. busy_o=1 from the first cycle after reset deassertion.
- States: S_IDLE, S_TX, S_WAIT_ACK, S_WAIT_BAT, S_ERROR.
  - A per-sequence "phase" register selects the next byte to send: RESET, LED_CMD or LED_ARG.
- S_TX:
  - tx_valid_o=1, tx_data_o held stable until a cycle with tx_valid_o & tx_ready_i.
  - On that cycle: go to S_WAIT_ACK, clear the timer; tx_valid_o=0 on the next cycle.
- S_WAIT_ACK (timer counts each cycle):
  - rx 0xFA, phase RESET: go to S_WAIT_BAT.
  - rx 0xFA, phase LED_CMD: go to S_TX with {5'b0, led_q}.
  - rx 0xFA, phase LED_ARG: go to S_IDLE.
  - rx 0xFE, or timer reaching ACK_TIMEOUT-1: retry_cnt++ and return to S_TX with the same byte.
  - If retry_cnt is already MAX_RETRIES on a retry: go to S_ERROR instead.
  - Any other rx byte: dropped, not forwarded, timer keeps running.
- S_WAIT_BAT:
  - rx 0xAA: kbd_ready_o=1, go to S_IDLE.
  - rx 0xFC, or timer reaching BAT_TIMEOUT-1: go to S_ERROR.
  - Other bytes: dropped.
- Retry counter and timer are cleared on every transition into S_TX caused by an ACK or a new sequence, but not on a retry.
- Same cycle rx_valid_i and timer expiry: the rx byte wins.
- S_IDLE:
  - rx byte forwarded: key_data_o=rx_data_i, key_valid_o=1 on the next cycle (1-cycle latency).
  - busy_o=0.
  - If led_pend: clear it and start an LED sequence (0xED).
- S_ERROR:
  - error_o=1, kbd_ready_o=0, busy_o=0.
  - rx bytes are forwarded as in S_IDLE.
  - LED requests are held pending, not serviced.
- led_req_i in any state: led_pend=1, led_q=led_i. A later request before service overwrites led_q (last wins).
- kbd_reset_i in any state:
  - Abort the current sequence (tx_valid_o drops next cycle).
  - Clear error_o and kbd_ready_o; go to S_TX with 0xFF.
  - Takes priority over pending LED and over same-cycle rx. led_pend is retained.
- rst_i asserted mid-sequence: immediate return to reset values.

Decomposition:
- Package common gets:
  - Constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED, PS2_RSP_ACK=8'hFA, PS2_RSP_RESEND=8'hFE, PS2_RSP_BAT_OK=8'hAA, PS2_RSP_BAT_FAIL=8'hFC.
  - Enums ps2_seq_state_t and ps2_seq_phase_t.
- Sub-module ps2_timeout_timer: loadable down-counter with clear and expire pulse, width sized from max(ACK_TIMEOUT, BAT_TIMEOUT).

Test Plan:
All scenarios use ACK_TIMEOUT=100, BAT_TIMEOUT=1000, MAX_RETRIES=2, with tx_ready_i high 3 cycles after tx_valid_o.
- Bring-up: release reset; respond 0xFA then 0xAA -> single tx 0xFF, kbd_ready_o=1, busy_o=0, no key_valid_o pulses.
- LED update: led_req_i with led_i=3'b101 in S_IDLE; ACK both bytes -> tx sequence 0xED then 0x05, busy_o drops after the second ACK.
- Resend/timeout: reply 0xFE to 0xED, then stay silent -> 0xED sent 3 times total, then error_o=1. A following kbd_reset_i -> error_o=0, tx 0xFF.
- BAT fail: ACK reset, then rx 0xFC -> error_o=1, kbd_ready_o=0. Rx 0x1C afterwards -> key_data_o=0x1C pulse.
- Scancode path: in S_IDLE rx 0x1C, 0xF0, 0x1C on consecutive strobes -> three key_valid_o pulses, each 1 cycle after its strobe, with matching data. During S_WAIT_ACK, rx 0x1C -> not forwarded.
- Reset mid-operation: assert rst_i while tx_valid_o=1 -> all outputs 0 that cycle, bring-up restarts after deassertion.
